// File: rtl/ht16d35a_spi_pkg.sv
// Shared types for the HT16D35A / TM1638-style 3-wire SPI master.
package ht16d35a_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    WRITE,
    TURNAROUND,
    READ,
    CS_HOLD,
    CS_HIGH
  } spi_state_e;

endpackage

// File: rtl/spi_half_period_timer.sv
// Down-counter that paces the SPI FSM; a phase lasts exactly load_val clocks.
module spi_half_period_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val - CNT_W'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/ht16d35a_spi_controller.sv
// 3-wire SPI master: latch a command, shift it out, optionally turn DIO around
// and read back a reply, framed by chip select with setup/hold/high times.
module ht16d35a_spi_controller
  import ht16d35a_spi_pkg::*;
#(
  parameter int NUM_SELECTS    = 1,
  parameter int CLK_DIV        = 20,
  parameter int OUT_BYTES      = 5,
  parameter int IN_BYTES       = 4,
  parameter int ALL_DONE_DELAY = 1,
  parameter int LSB_FIRST      = 1,
  localparam int OUT_SZ        = $clog2(OUT_BYTES + 1),
  localparam int IN_SZ         = $clog2(IN_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic                   sck,
  output logic                   dio_o,
  output logic                   dio_e,
  input  logic                   dio_i,
  output logic [NUM_SELECTS-1:0] cs,
  output logic                   busy,
  input  logic                   activate,
  input  logic [NUM_SELECTS-1:0] in_cs,
  input  logic [7:0]             out_data [OUT_BYTES],
  input  logic [OUT_SZ-1:0]      out_count,
  input  logic [IN_SZ-1:0]       in_count,
  output logic [7:0]             in_data  [IN_BYTES]
);

  localparam int HALF      = CLK_DIV / 2;
  localparam int HOLD_CLKS = (ALL_DONE_DELAY > 0) ? ALL_DONE_DELAY * CLK_DIV : 1;
  localparam int TMR_MAX   = (HOLD_CLKS > CLK_DIV) ? HOLD_CLKS : CLK_DIV;
  localparam int TW        = $clog2(TMR_MAX + 1);
  localparam int WI_W      = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
  localparam int RI_W      = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;

  function automatic logic [OUT_SZ-1:0] clamp_out(input logic [OUT_SZ-1:0] n);
    return (n > OUT_SZ'(OUT_BYTES)) ? OUT_SZ'(OUT_BYTES) : n;
  endfunction

  function automatic logic [IN_SZ-1:0] clamp_in(input logic [IN_SZ-1:0] n);
    return (n > IN_SZ'(IN_BYTES)) ? IN_SZ'(IN_BYTES) : n;
  endfunction

  function automatic logic tx_bit(input logic [7:0] b, input logic [2:0] i);
    return (LSB_FIRST != 0) ? b[i] : b[3'd7 - i];
  endfunction

  spi_state_e            state, state_nx;
  logic                  ph, ph_nx;
  logic [2:0]            bit_idx, bit_nx;
  logic [WI_W-1:0]       wr_idx, wr_nx;
  logic [RI_W-1:0]       rd_idx, rd_nx;
  logic                  sck_nx, dio_o_nx, dio_e_nx, busy_nx;
  logic [NUM_SELECTS-1:0] cs_nx;
  logic                  start, sample, tmr_load, tmr_done;
  logic [TW-1:0]         tmr_val;
  logic [7:0]            tx_q [OUT_BYTES];
  logic [OUT_SZ-1:0]     oc_q;
  logic [IN_SZ-1:0]      ic_q;
  logic [7:0]            rx_sr, rx_nxt;
  logic                  last_wr, last_rd;

  spi_half_period_timer #(.CNT_W(TW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  assign last_wr = (wr_idx == WI_W'(oc_q - OUT_SZ'(1)));
  assign last_rd = (rd_idx == RI_W'(ic_q - IN_SZ'(1)));
  assign rx_nxt  = (LSB_FIRST != 0) ? {dio_i, rx_sr[7:1]} : {rx_sr[6:0], dio_i};

  // ph=0 is the SCK-low half of a bit, ph=1 the SCK-high half.
  always_comb begin
    state_nx = state;
    ph_nx    = ph;
    bit_nx   = bit_idx;
    wr_nx    = wr_idx;
    rd_nx    = rd_idx;
    sck_nx   = sck;
    dio_o_nx = dio_o;
    dio_e_nx = dio_e;
    cs_nx    = cs;
    busy_nx  = busy;
    start    = 1'b0;
    sample   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = TW'(HALF);
    unique case (state)
      IDLE: begin
        if (activate) begin
          start    = 1'b1;
          busy_nx  = 1'b1;
          cs_nx    = ~in_cs;
          tmr_load = 1'b1;
          state_nx = CS_SETUP;
        end
      end
      CS_SETUP: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (oc_q != '0) begin
            state_nx = WRITE;
            sck_nx   = 1'b0;
            dio_e_nx = 1'b1;
            ph_nx    = 1'b0;
            bit_nx   = 3'd0;
            wr_nx    = '0;
            dio_o_nx = tx_bit(tx_q[WI_W'(0)], 3'd0);
          end else if (ic_q != '0) begin
            state_nx = TURNAROUND;
          end else begin
            state_nx = CS_HOLD;
            tmr_val  = TW'(HOLD_CLKS);
          end
        end
      end
      WRITE: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (!ph) begin
            sck_nx = 1'b1;
            ph_nx  = 1'b1;
          end else if (bit_idx == 3'd7 && last_wr) begin
            dio_e_nx = 1'b0;
            dio_o_nx = 1'b0;
            if (ic_q != '0) begin
              state_nx = TURNAROUND;
            end else begin
              state_nx = CS_HOLD;
              tmr_val  = TW'(HOLD_CLKS);
            end
          end else begin
            if (bit_idx == 3'd7) wr_nx = wr_idx + WI_W'(1);
            bit_nx   = bit_idx + 3'd1;
            sck_nx   = 1'b0;
            ph_nx    = 1'b0;
            dio_o_nx = tx_bit(tx_q[wr_nx], bit_nx);
          end
        end
      end
      TURNAROUND: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          state_nx = READ;
          sck_nx   = 1'b0;
          ph_nx    = 1'b0;
          bit_nx   = 3'd0;
          rd_nx    = '0;
        end
      end
      READ: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (!ph) begin
            sck_nx = 1'b1;
            ph_nx  = 1'b1;
            sample = 1'b1;
          end else if (bit_idx == 3'd7 && last_rd) begin
            state_nx = CS_HOLD;
            tmr_val  = TW'(HOLD_CLKS);
          end else begin
            if (bit_idx == 3'd7) rd_nx = rd_idx + RI_W'(1);
            bit_nx = bit_idx + 3'd1;
            sck_nx = 1'b0;
            ph_nx  = 1'b0;
          end
        end
      end
      CS_HOLD: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = TW'(CLK_DIV);
          cs_nx    = '1;
          state_nx = CS_HIGH;
        end
      end
      CS_HIGH: begin
        if (tmr_done) begin
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ph      <= 1'b0;
      bit_idx <= 3'd0;
      wr_idx  <= '0;
      rd_idx  <= '0;
      sck     <= 1'b1;
      dio_o   <= 1'b0;
      dio_e   <= 1'b0;
      cs      <= '1;
      busy    <= 1'b0;
      oc_q    <= '0;
      ic_q    <= '0;
      for (int k = 0; k < IN_BYTES; k++) in_data[k] <= '0;
    end else begin
      state   <= state_nx;
      ph      <= ph_nx;
      bit_idx <= bit_nx;
      wr_idx  <= wr_nx;
      rd_idx  <= rd_nx;
      sck     <= sck_nx;
      dio_o   <= dio_o_nx;
      dio_e   <= dio_e_nx;
      cs      <= cs_nx;
      busy    <= busy_nx;
      if (start) begin
        oc_q <= clamp_out(out_count);
        ic_q <= clamp_in(in_count);
      end
      if (sample && bit_idx == 3'd7) in_data[rd_idx] <= rx_nxt;
    end
  end

  // Command bytes and the receive shifter carry data only; no reset needed.
  always_ff @(posedge clk) begin
    if (start)  tx_q  <= out_data;
    if (sample) rx_sr <= rx_nxt;
  end

endmodule

// File: tb/tb_ht16d35a_spi_controller.sv
// Directed bench for ht16d35a_spi_controller: LSB-first instance A, MSB-first instance B.
module tb_ht16d35a_spi_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       sck_a, dio_o_a, dio_e_a, dio_i_a, busy_a, act_a;
  logic [0:0] cs_a, in_cs_a;
  logic [7:0] od_a [5];
  logic [2:0] oc_a, ic_a;
  logic [7:0] id_a [4];

  logic       sck_b, dio_o_b, dio_e_b, busy_b, act_b;
  logic       dio_i_b = 1'b0;
  logic [0:0] cs_b, in_cs_b;
  logic [7:0] od_b [5];
  logic [2:0] oc_b, ic_b;
  logic [7:0] id_b [4];

  ht16d35a_spi_controller #(.LSB_FIRST(1)) dut_a (
    .clk(clk), .reset_n(rst_n), .sck(sck_a), .dio_o(dio_o_a), .dio_e(dio_e_a),
    .dio_i(dio_i_a), .cs(cs_a), .busy(busy_a), .activate(act_a), .in_cs(in_cs_a),
    .out_data(od_a), .out_count(oc_a), .in_count(ic_a), .in_data(id_a)
  );

  ht16d35a_spi_controller #(.LSB_FIRST(0)) dut_b (
    .clk(clk), .reset_n(rst_n), .sck(sck_b), .dio_o(dio_o_b), .dio_e(dio_e_b),
    .dio_i(dio_i_b), .cs(cs_b), .busy(busy_b), .activate(act_b), .in_cs(in_cs_b),
    .out_data(od_b), .out_count(oc_b), .in_count(ic_b), .in_data(id_b)
  );

  // Wire-side observer for A: write rises have dio_e=1, read rises dio_e=0.
  int         a_wr = 0, a_rd = 0, a_gap = 0, a_last = 0, a_csr = 0;
  int         wr_base = 0, rd_base = 0;
  logic       a_bits [256];
  logic       sck_pa = 1'b1, cs_pa = 1'b1;
  logic [31:0] rd_word = '0;

  assign dio_i_a = rd_word[5'(a_rd - rd_base)];

  always @(negedge clk) begin
    if (sck_a && !sck_pa) begin
      if (dio_e_a) begin
        if (a_wr > wr_base && (cyc - a_last) != 20) a_gap++;
        a_bits[8'(a_wr)] = dio_o_a;
        a_wr++;
      end else begin
        a_rd++;
      end
      a_last = cyc;
    end
    if (cs_a[0] && !cs_pa) a_csr = cyc;
    sck_pa = sck_a;
    cs_pa  = cs_a[0];
  end

  int   b_wr = 0, b_busyr = 0;
  logic b_bits [16];
  logic sck_pb = 1'b1, busy_pb = 1'b0;

  always @(negedge clk) begin
    if (sck_b && !sck_pb && dio_e_b) begin
      b_bits[4'(b_wr)] = dio_o_b;
      b_wr++;
    end
    if (busy_b && !busy_pb) b_busyr++;
    sck_pb  = sck_b;
    busy_pb = busy_b;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack_in();
    return {id_a[3], id_a[2], id_a[1], id_a[0]};
  endfunction

  task automatic run_a(input string tag, input logic [39:0] od, input logic [2:0] oc,
                       input logic [2:0] ic, input logic [31:0] rw,
                       input int exp_wr, input int exp_rd);
    int wb, rb, gb, fall, n;
    logic [63:0] got, exp;
    for (int i = 0; i < 5; i++) od_a[i] = od[8*i +: 8];
    oc_a = oc; ic_a = ic; in_cs_a = 1'b1; rd_word = rw;
    wb = a_wr; rb = a_rd; gb = a_gap;
    wr_base = a_wr; rd_base = a_rd;
    @(negedge clk); act_a = 1'b1;
    @(negedge clk);
    check({tag, "_busy_rise"}, 64'(busy_a), 64'd1);
    check({tag, "_cs_low"}, 64'(cs_a), 64'd0);
    act_a = 1'b0;
    // Scramble the request inputs: the transaction must use the latched copy.
    for (int i = 0; i < 5; i++) od_a[i] = ~od[8*i +: 8];
    oc_a = 3'd0; ic_a = 3'd0;
    n = 0;
    while (busy_a === 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_finish"}, 64'(n < 5000), 64'd1);
    fall = cyc;
    check({tag, "_wr_rises"}, 64'(a_wr - wb), 64'(exp_wr));
    check({tag, "_rd_rises"}, 64'(a_rd - rb), 64'(exp_rd));
    check({tag, "_sck_period"}, 64'(a_gap - gb), 64'd0);
    got = '0;
    for (int i = 0; i < exp_wr && i < 64; i++) got[i] = a_bits[8'(wb + i)];
    exp = {24'd0, od};
    if (exp_wr < 64) exp = exp & ((64'd1 << exp_wr) - 64'd1);
    check({tag, "_wr_bits"}, got, exp);
    if (exp_wr + exp_rd > 0) check({tag, "_cs_hold"}, 64'((a_csr - a_last) >= 20), 64'd1);
    check({tag, "_cs_high_time"}, 64'(fall - a_csr), 64'd20);
  endtask

  initial begin
    int n, wb, bb, br;
    logic [63:0] got;
    rst_n = 1'b0;
    act_a = 1'b0; in_cs_a = 1'b1; oc_a = '0; ic_a = '0;
    act_b = 1'b0; in_cs_b = 1'b1; oc_b = '0; ic_b = '0;
    for (int i = 0; i < 5; i++) begin od_a[i] = '0; od_b[i] = '0; end
    repeat (3) @(negedge clk);
    check("rst_sck", 64'(sck_a), 64'd1);
    check("rst_cs", 64'(cs_a), 64'd1);
    check("rst_dio_e", 64'(dio_e_a), 64'd0);
    check("rst_dio_o", 64'(dio_o_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_in_data", 64'(pack_in()), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 0x40 LSB-first: wire sequence 0,0,0,0,0,0,1,0 packs first-bit-in-bit0 to 0x40.
    run_a("w1", 40'h40, 3'd1, 3'd0, 32'h0, 8, 0);
    run_a("w5", 40'h08_04_02_01_C0, 3'd5, 3'd0, 32'h0, 40, 0);
    run_a("clamp", 40'h55_AA_33_CC_F0, 3'd7, 3'd0, 32'h0, 40, 0);
    run_a("rd4", 40'h42, 3'd1, 3'd4, 32'h88_44_22_11, 8, 32);
    check("rd4_in_data", 64'(pack_in()), 64'h88_44_22_11);
    run_a("rd1", 40'h0, 3'd0, 3'd1, 32'h0000_005A, 0, 8);
    check("rd1_in_data", 64'(pack_in()), 64'h88_44_22_5A);
    run_a("zero", 40'h0, 3'd0, 3'd0, 32'h0, 0, 0);

    // MSB-first 0x40 with activate held well into the transaction.
    od_b[0] = 8'h40; oc_b = 3'd1; ic_b = 3'd0;
    bb = b_wr; br = b_busyr;
    @(negedge clk); act_b = 1'b1;
    repeat (100) @(negedge clk);
    check("msb_busy_held", 64'(busy_b), 64'd1);
    act_b = 1'b0;
    n = 0;
    while (busy_b === 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("msb_finish", 64'(n < 5000), 64'd1);
    repeat (40) @(negedge clk);
    check("msb_one_txn", 64'(b_busyr - br), 64'd1);
    check("msb_rises", 64'(b_wr - bb), 64'd8);
    got = '0;
    for (int i = 0; i < 8; i++) got[i] = b_bits[4'(bb + i)];
    // Wire sequence 0,1,0,0,0,0,0,0 packed first-bit-in-bit0.
    check("msb_bits", got, 64'h02);

    // Abort during the low half of bit 5 of a write.
    for (int i = 0; i < 5; i++) od_a[i] = 8'hFF;
    oc_a = 3'd1; ic_a = 3'd0;
    wb = a_wr;
    @(negedge clk); act_a = 1'b1;
    @(negedge clk); act_a = 1'b0;
    n = 0;
    while ((a_wr - wb) < 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_bit5", 64'(n < 2000), 64'd1);
    repeat (12) @(negedge clk);
    check("abort_mid_write", 64'({dio_e_a, sck_a}), 64'b10);
    rst_n = 1'b0;
    #1;
    check("abort_sck", 64'(sck_a), 64'd1);
    check("abort_cs", 64'(cs_a), 64'd1);
    check("abort_busy", 64'(busy_a), 64'd0);
    check("abort_dio_e", 64'(dio_e_a), 64'd0);
    check("abort_in_data", 64'(pack_in()), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_a("recover", 40'h8F, 3'd1, 3'd0, 32'h0, 8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
